// File: rtl/icache_ctrl.sv
// Direct-mapped instruction cache feeding the IF stage.
// Hits return data combinationally; misses run a word-by-word refill over the memory port.
module icache_ctrl #(
    parameter int LINES = 64,
    parameter int WPL   = 4
) (
    input  logic        Clk,
    input  logic        Rst,
    input  logic        ReqValid,
    input  logic [31:0] ReqAddr,
    input  logic        InvalidateAll,
    output logic [31:0] Instr,
    output logic        Imiss,
    output logic        MemReq,
    output logic [31:0] MemAddr,
    input  logic        MemAck,
    input  logic [31:0] MemData
);
    localparam int OFFW = $clog2(WPL);
    localparam int IDXW = $clog2(LINES);
    localparam int TAGW = 32 - 2 - OFFW - IDXW;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        REFILL = 2'd1,
        FILLED = 2'd2
    } state_e;

    state_e            state_q, state_d;
    logic [OFFW-1:0]   cnt_q, cnt_d;
    logic [IDXW-1:0]   miss_idx_q, miss_idx_d;
    logic [TAGW-1:0]   miss_tag_q, miss_tag_d;
    logic              inv_pend_q, inv_pend_d;
    logic [LINES-1:0]  valid_q, valid_d;
    logic [TAGW-1:0]   tag_q  [LINES];
    logic [31:0]       data_q [LINES*WPL];

    logic [OFFW-1:0]   req_off_s;
    logic [IDXW-1:0]   req_idx_s;
    logic [TAGW-1:0]   req_tag_s;
    logic              hit_s;
    logic              wr_en_s;
    logic              last_word_s;

    assign req_off_s   = ReqAddr[OFFW+1:2];
    assign req_idx_s   = ReqAddr[IDXW+OFFW+1:OFFW+2];
    assign req_tag_s   = ReqAddr[31:IDXW+OFFW+2];
    assign wr_en_s     = ~Rst & (state_q == REFILL) & MemAck;
    assign last_word_s = (cnt_q == OFFW'(WPL - 1));

    // Lookup and output decode; everything is forced quiet while reset is held
    always_comb begin
        hit_s   = ReqValid & valid_q[req_idx_s] & (tag_q[req_idx_s] == req_tag_s)
                & (state_q == IDLE);
        Instr   = 32'd0;
        Imiss   = 1'b0;
        MemReq  = 1'b0;
        MemAddr = 32'd0;
        if (!Rst) begin
            if (hit_s) begin
                Instr = data_q[{req_idx_s, req_off_s}];
            end else begin
                Instr = 32'd0;
            end
            Imiss  = (ReqValid & ~hit_s) | (state_q != IDLE);
            MemReq = (state_q == REFILL);
            if (state_q == REFILL) begin
                MemAddr = {miss_tag_q, miss_idx_q, cnt_q, 2'b00};
            end else begin
                MemAddr = 32'd0;
            end
        end else begin
            Instr = 32'd0;
        end
    end

    // Refill FSM next-state and valid-bit bookkeeping
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        miss_idx_d = miss_idx_q;
        miss_tag_d = miss_tag_q;
        inv_pend_d = inv_pend_q;
        valid_d    = valid_q;
        case (state_q)
            IDLE: begin
                inv_pend_d = 1'b0;
                if (InvalidateAll) begin
                    valid_d = '0;
                end else begin
                    valid_d = valid_q;
                end
                // Clearing valid on entry keeps a half-written line from ever hitting
                if (ReqValid && !hit_s) begin
                    miss_idx_d         = req_idx_s;
                    miss_tag_d         = req_tag_s;
                    cnt_d              = '0;
                    valid_d[req_idx_s] = 1'b0;
                    state_d            = REFILL;
                end else begin
                    state_d = IDLE;
                end
            end
            REFILL: begin
                if (InvalidateAll) begin
                    inv_pend_d = 1'b1;
                end else begin
                    inv_pend_d = inv_pend_q;
                end
                if (MemAck) begin
                    cnt_d = cnt_q + OFFW'(1);
                    if (last_word_s) begin
                        valid_d[miss_idx_q] = 1'b1;
                        state_d             = FILLED;
                    end else begin
                        state_d = REFILL;
                    end
                end else begin
                    state_d = REFILL;
                end
            end
            FILLED: begin
                state_d = IDLE;
                if (inv_pend_q || InvalidateAll) begin
                    valid_d    = '0;
                    inv_pend_d = 1'b0;
                end else begin
                    valid_d = valid_q;
                end
            end
            default: begin
                state_d    = IDLE;
                inv_pend_d = 1'b0;
            end
        endcase
    end

    // Control state with synchronous reset
    always_ff @(posedge Clk) begin
        if (Rst) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            miss_idx_q <= '0;
            miss_tag_q <= '0;
            inv_pend_q <= 1'b0;
            valid_q    <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            miss_idx_q <= miss_idx_d;
            miss_tag_q <= miss_tag_d;
            inv_pend_q <= inv_pend_d;
            valid_q    <= valid_d;
        end
    end

    // Data and tag arrays; contents are qualified by valid_q so they need no reset
    always_ff @(posedge Clk) begin
        if (wr_en_s) begin
            data_q[{miss_idx_q, cnt_q}] <= MemData;
            if (last_word_s) begin
                tag_q[miss_idx_q] <= miss_tag_q;
            end
        end
    end

endmodule

// File: tb/tb_icache_ctrl.sv
// Directed bench for icache_ctrl: table of lookup vectors plus hand-written refill sequences.
module tb_icache_ctrl;
    logic        Clk;
    logic        Rst;
    logic        ReqValid;
    logic [31:0] ReqAddr;
    logic        InvalidateAll;
    logic [31:0] Instr;
    logic        Imiss;
    logic        MemReq;
    logic [31:0] MemAddr;
    logic        MemAck;
    logic [31:0] MemData;

    int nchecks = 0;
    int nerr    = 0;

    typedef struct {
        logic        v;
        logic [31:0] addr;
        logic [31:0] instr;
        logic        imiss;
    } vec_t;

    vec_t vecs [8];

    icache_ctrl #(.LINES(64), .WPL(4)) dut (
        .Clk(Clk), .Rst(Rst), .ReqValid(ReqValid), .ReqAddr(ReqAddr),
        .InvalidateAll(InvalidateAll), .Instr(Instr), .Imiss(Imiss),
        .MemReq(MemReq), .MemAddr(MemAddr), .MemAck(MemAck), .MemData(MemData)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        nchecks++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: actual %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    // Combinational lookup in IDLE; ReqValid is dropped before the edge so no refill starts
    task automatic look(input string name, input logic v, input logic [31:0] a,
                        input logic [31:0] ei, input logic em);
        ReqValid = v;
        ReqAddr  = a;
        #1;
        chk({name, "_instr"}, Instr, ei);
        chk({name, "_imiss"}, {31'd0, Imiss}, {31'd0, em});
        chk({name, "_memreq"}, {31'd0, MemReq}, 32'd0);
        ReqValid = 1'b0;
        tick();
    endtask

    // Miss on base, serve WPL words with 'stall' idle cycles before each ack,
    // optionally pulse InvalidateAll together with ack number inv_word; ends back in IDLE
    task automatic fill_line(input logic [31:0] base, input int stall, input int inv_word);
        ReqAddr  = base;
        ReqValid = 1'b1;
        #1;
        chk("miss_imiss", {31'd0, Imiss}, 32'd1);
        chk("miss_no_req_yet", {31'd0, MemReq}, 32'd0);
        tick();
        ReqValid = 1'b0;
        for (int w = 0; w < 4; w++) begin
            for (int s = 0; s < stall; s++) begin
                #1;
                chk("stall_memreq", {31'd0, MemReq}, 32'd1);
                chk("stall_memaddr", MemAddr, base + 32'(4 * w));
                chk("stall_imiss", {31'd0, Imiss}, 32'd1);
                tick();
            end
            MemAck        = 1'b1;
            MemData       = mem_word(base + 32'(4 * w));
            InvalidateAll = (w == inv_word);
            #1;
            chk("ack_memreq", {31'd0, MemReq}, 32'd1);
            chk("ack_memaddr", MemAddr, base + 32'(4 * w));
            tick();
            MemAck        = 1'b0;
            InvalidateAll = 1'b0;
        end
        #1;
        chk("filled_memreq", {31'd0, MemReq}, 32'd0);
        chk("filled_imiss", {31'd0, Imiss}, 32'd1);
        tick();
    endtask

    initial begin
        Rst           = 1'b1;
        ReqValid      = 1'b1;
        ReqAddr       = 32'h0000_0100;
        InvalidateAll = 1'b0;
        MemAck        = 1'b0;
        MemData       = 32'd0;

        // Lookups valid once line 0x100 holds words 0x100..0x10C
        vecs[0] = '{1'b1, 32'h0000_0100, mem_word(32'h0000_0100), 1'b0};
        vecs[1] = '{1'b1, 32'h0000_0104, mem_word(32'h0000_0104), 1'b0};
        vecs[2] = '{1'b1, 32'h0000_010C, mem_word(32'h0000_010C), 1'b0};
        vecs[3] = '{1'b1, 32'h0000_0103, mem_word(32'h0000_0100), 1'b0};
        vecs[4] = '{1'b1, 32'h0000_0500, 32'd0, 1'b1};
        vecs[5] = '{1'b1, 32'h0000_0110, 32'd0, 1'b1};
        vecs[6] = '{1'b0, 32'h0000_0100, 32'd0, 1'b0};
        vecs[7] = '{1'b0, 32'h0000_0700, 32'd0, 1'b0};

        // Reset: outputs quiet even with a valid request present
        tick();
        tick();
        tick();
        chk("rst_instr", Instr, 32'd0);
        chk("rst_imiss", {31'd0, Imiss}, 32'd0);
        chk("rst_memreq", {31'd0, MemReq}, 32'd0);
        chk("rst_memaddr", MemAddr, 32'd0);
        Rst      = 1'b0;
        ReqValid = 1'b0;
        tick();

        // Basic miss and refill, then hit two cycles after the last ack
        fill_line(32'h0000_0100, 0, -1);
        look("t1_hit108", 1'b1, 32'h0000_0108, mem_word(32'h0000_0108), 1'b0);

        for (int i = 0; i < 8; i++) begin
            look($sformatf("vec%0d", i), vecs[i].v, vecs[i].addr, vecs[i].instr, vecs[i].imiss);
        end

        // Conflict miss evicts 0x100
        fill_line(32'h0000_0500, 0, -1);
        look("t2_hit504", 1'b1, 32'h0000_0504, mem_word(32'h0000_0504), 1'b0);
        look("t2_miss100", 1'b1, 32'h0000_0100, 32'd0, 1'b1);

        // Slow memory: five idle cycles before every ack
        fill_line(32'h0000_0140, 5, -1);
        for (int w = 0; w < 4; w++) begin
            look($sformatf("t3_w%0d", w), 1'b1, 32'h0000_0140 + 32'(4 * w),
                 mem_word(32'h0000_0140 + 32'(4 * w)), 1'b0);
        end

        // InvalidateAll during a refill clears every line, including the new one
        fill_line(32'h0000_0100, 0, -1);
        look("t4_hit100", 1'b1, 32'h0000_0100, mem_word(32'h0000_0100), 1'b0);
        fill_line(32'h0000_0200, 0, 1);
        look("t4_miss200", 1'b1, 32'h0000_0200, 32'd0, 1'b1);
        look("t4_miss100", 1'b1, 32'h0000_0100, 32'd0, 1'b1);
        look("t4_miss140", 1'b1, 32'h0000_0140, 32'd0, 1'b1);

        // Reset after two of four acks
        ReqAddr  = 32'h0000_0300;
        ReqValid = 1'b1;
        tick();
        ReqValid = 1'b0;
        for (int w = 0; w < 2; w++) begin
            MemAck  = 1'b1;
            MemData = mem_word(32'h0000_0300 + 32'(4 * w));
            tick();
            MemAck = 1'b0;
        end
        #1;
        chk("t5_addr_before_rst", MemAddr, 32'h0000_0308);
        Rst = 1'b1;
        tick();
        Rst = 1'b0;
        #1;
        chk("t5_memreq_after_rst", {31'd0, MemReq}, 32'd0);
        chk("t5_memaddr_after_rst", MemAddr, 32'd0);
        chk("t5_imiss_after_rst", {31'd0, Imiss}, 32'd0);
        MemAck  = 1'b1;
        MemData = 32'hDEAD_BEEF;
        tick();
        MemAck = 1'b0;
        #1;
        chk("t5_stray_memreq", {31'd0, MemReq}, 32'd0);
        look("t5_miss300", 1'b1, 32'h0000_0300, 32'd0, 1'b1);
        look("t5_miss308", 1'b1, 32'h0000_0308, 32'd0, 1'b1);
        fill_line(32'h0000_0300, 1, -1);
        for (int w = 0; w < 4; w++) begin
            look($sformatf("t5_w%0d", w), 1'b1, 32'h0000_0300 + 32'(4 * w),
                 mem_word(32'h0000_0300 + 32'(4 * w)), 1'b0);
        end

        // InvalidateAll while idle
        InvalidateAll = 1'b1;
        tick();
        InvalidateAll = 1'b0;
        look("idle_inv_miss300", 1'b1, 32'h0000_0300, 32'd0, 1'b1);

        $display("Simulation finished: %0d checks, %0d errors", nchecks, nerr);
        $finish;
    end
endmodule
